// File: rtl/uart_fmt_pkg.sv
// Shared encodings for the UART text formatters: FSM states and the ASCII
// characters used to build a printed line.
package uart_fmt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SKIP     = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT     = 3'd3,
        ST_EOL_SEND = 3'd4
    } state_t;

    localparam logic [7:0] CHR_0  = 8'h30;
    localparam logic [7:0] CHR_A  = 8'h41;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;

endpackage

// File: rtl/hex_digit_ascii.sv
// Maps one 4-bit digit to its uppercase ASCII character ('0'-'9', 'A'-'F').
module hex_digit_ascii
    import uart_fmt_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) ascii = CHR_0 + {4'b0000, nibble};
        else                ascii = CHR_A + {4'b0000, nibble} - 8'd10;
    end

endmodule

// File: rtl/uart_num_printer.sv
// Prints a captured value as one text line (binary or hex, MSB first, then
// LF or CR LF), handing one byte at a time to the uart_tx2 byte transmitter.
//
// state       | meaning
// ST_IDLE     | ready for a new value
// ST_SKIP     | dropping leading zero digits; emits the first kept digit itself
// ST_SEND     | pulse TX_DV with the digit at idx
// ST_WAIT     | byte in flight, hold TX_BYTE until TX_DONE
// ST_EOL_SEND | pulse TX_DV with CR or LF
module uart_num_printer
    import uart_fmt_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit SUPPRESS_ZEROS = 1'b0,
    parameter bit EOL_CRLF       = 1'b0
) (
    input  logic             ICE_CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_HEX,
    output logic             TX_DV,
    output logic [7:0]       TX_BYTE,
    input  logic             TX_DONE,
    output logic             BUSY
);

    localparam int ND_BIN = WIDTH;
    localparam int ND_HEX = (WIDTH + 3) / 4;
    localparam int PAD_W  = ND_HEX * 4;

    state_t           state;
    logic [PAD_W-1:0] data_q;
    logic             hex_q;
    logic             in_eol;
    logic [6:0]       idx;
    logic [3:0]       nibble;
    logic [7:0]       digit_chr;
    logic             digit_zero;

    // Binary digits reuse the hex character map with the bit in the LSB.
    always_comb begin
        nibble     = hex_q ? 4'(data_q >> {idx, 2'b00}) : {3'b000, 1'(data_q >> idx)};
        digit_zero = (nibble == 4'h0);
    end

    hex_digit_ascii u_chr (
        .nibble (nibble),
        .ascii  (digit_chr)
    );

    assign BUSY = ~IN_READY;

    always_ff @(posedge ICE_CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            TX_DV    <= 1'b0;
            TX_BYTE  <= 8'h00;
            idx      <= '0;
            data_q   <= '0;
            hex_q    <= 1'b0;
            in_eol   <= 1'b0;
            IN_READY <= 1'b1;
        end else begin
            TX_DV <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        data_q   <= PAD_W'(IN_DATA);
                        hex_q    <= IN_HEX;
                        idx      <= IN_HEX ? 7'(ND_HEX - 1) : 7'(ND_BIN - 1);
                        in_eol   <= 1'b0;
                        IN_READY <= 1'b0;
                        state    <= SUPPRESS_ZEROS ? ST_SKIP : ST_SEND;
                    end
                end
                ST_SKIP: begin
                    if (idx != 7'd0 && digit_zero) begin
                        idx <= idx - 7'd1;
                    end else begin
                        TX_BYTE <= digit_chr;
                        TX_DV   <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                ST_SEND: begin
                    TX_BYTE <= digit_chr;
                    TX_DV   <= 1'b1;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (TX_DONE) begin
                        if (!in_eol && idx != 7'd0) begin
                            idx   <= idx - 7'd1;
                            state <= ST_SEND;
                        end else if (!in_eol || TX_BYTE == CHR_CR) begin
                            in_eol <= 1'b1;
                            state  <= ST_EOL_SEND;
                        end else begin
                            IN_READY <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_EOL_SEND: begin
                    // The byte still held is the last digit on the first pass, CR on the second.
                    TX_BYTE <= (EOL_CRLF && TX_BYTE != CHR_CR) ? CHR_CR : CHR_LF;
                    TX_DV   <= 1'b1;
                    state   <= ST_WAIT;
                end
                default: begin
                    IN_READY <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_num_printer.sv
// Bench for uart_num_printer: five configurations side by side, each fed by a
// uart_tx2 stand-in that answers every TX_DV with TX_DONE 20 cycles later.
module tb_uart_num_printer;

    localparam int NI = 5;
    localparam int P_W  [NI] = '{8, 10, 8, 8, 13};
    localparam bit P_SZ [NI] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam bit P_CR [NI] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst      [NI];
    logic        in_valid [NI];
    logic        in_ready [NI];
    logic [63:0] in_data  [NI];
    logic        in_hex   [NI];
    logic        tx_dv    [NI];
    logic [7:0]  tx_byte  [NI];
    logic        tx_done  [NI] = '{default: 1'b0};
    logic        busy     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_num_printer #(
            .WIDTH          (P_W[g]),
            .SUPPRESS_ZEROS (P_SZ[g]),
            .EOL_CRLF       (P_CR[g])
        ) dut (
            .ICE_CLK  (clk),
            .RST      (rst[g]),
            .IN_VALID (in_valid[g]),
            .IN_READY (in_ready[g]),
            .IN_DATA  (in_data[g][P_W[g]-1:0]),
            .IN_HEX   (in_hex[g]),
            .TX_DV    (tx_dv[g]),
            .TX_BYTE  (tx_byte[g]),
            .TX_DONE  (tx_done[g]),
            .BUSY     (busy[g])
        );
    end

    int checks = 0;
    int failures = 0;

    // uart_tx2 stand-in and byte recorder
    int         cnt       [NI] = '{default: 0};
    int         cap_n     [NI] = '{default: 0};
    int         viol      [NI] = '{default: 0};
    int         first_dv  [NI] = '{default: -1};
    int         last_dv   [NI] = '{default: 0};
    int         last_done [NI] = '{default: 0};
    logic [7:0] held      [NI];
    bit         stray     [NI] = '{default: 1'b0};
    logic [7:0] cap       [NI][64];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            tx_done[i] = 1'b0;
            if (cnt[i] > 0) begin
                if (!stray[i] && tx_byte[i] !== held[i]) viol[i]++;
                if (tx_dv[i] !== 1'b0) viol[i]++;
                cnt[i]--;
                if (cnt[i] == 0) begin
                    tx_done[i]   = 1'b1;
                    last_done[i] = cyc;
                    stray[i]     = 1'b0;
                end
            end else if (tx_dv[i] === 1'b1) begin
                if (cap_n[i] == 0) first_dv[i] = cyc;
                else if (cap[i][cap_n[i]-1] != 8'h0A && cyc - last_dv[i] != 22) viol[i]++;
                last_dv[i] = cyc;
                if (cap_n[i] < 64) begin
                    cap[i][cap_n[i]] = tx_byte[i];
                    cap_n[i]++;
                end
                held[i] = tx_byte[i];
                cnt[i]  = 20;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: expected line and first-byte latency from the value by plain arithmetic.
    logic [7:0] exp_b [64];
    int         exp_n;
    int         exp_lat;

    task automatic model_line(input int i, input logic [63:0] value, input bit hex);
        string       digs;
        logic [63:0] radix, p, v;
        int          nd, k;
        int          dig [64];
        digs  = "0123456789ABCDEF";
        radix = hex ? 64'd16 : 64'd2;
        nd    = hex ? (P_W[i] + 3) / 4 : P_W[i];
        v     = value & ((64'd1 << P_W[i]) - 64'd1);
        p     = 64'd1;
        for (int j = 1; j < nd; j++) p = p * radix;
        for (int j = 0; j < nd; j++) begin
            dig[j] = int'((v / p) % radix);
            p      = p / radix;
        end
        k = 0;
        if (P_SZ[i]) while (k < nd - 1 && dig[k] == 0) k++;
        exp_n = 0;
        for (int j = k; j < nd; j++) begin
            exp_b[exp_n] = digs[dig[j]];
            exp_n++;
        end
        if (P_CR[i]) begin
            exp_b[exp_n] = 8'h0D;
            exp_n++;
        end
        exp_b[exp_n] = 8'h0A;
        exp_n++;
        exp_lat = 1 + k;
    endtask

    task automatic wait_ready(input int i, output bit ok);
        int t;
        t  = 0;
        ok = in_ready[i];
        while (!ok && t < 4000) begin
            @(negedge clk);
            t++;
            ok = in_ready[i];
        end
    endtask

    task automatic start_xfer(input int i, input logic [63:0] value, input bit hex,
                              output int xfer_cyc, output bit ok);
        @(negedge clk);
        wait_ready(i, ok);
        xfer_cyc = 0;
        if (ok) begin
            in_valid[i] = 1'b1;
            in_data[i]  = value;
            in_hex[i]   = hex;
            @(negedge clk);
            xfer_cyc    = cyc;
            in_valid[i] = 1'b0;
            in_data[i]  = {$urandom, $urandom};
            in_hex[i]   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_capture(input int i, input string name);
        int bad;
        bad = -1;
        check(cap_n[i] == exp_n, {name, " byte_count"}, cap_n[i], exp_n);
        for (int j = 0; j < exp_n; j++)
            if (bad < 0 && (j >= cap_n[i] || cap[i][j] !== exp_b[j])) bad = j;
        check(bad < 0, {name, " bytes"}, (bad < 0) ? 0 : cap[i][bad], (bad < 0) ? 0 : exp_b[bad]);
        check(viol[i] == 0, {name, " protocol"}, viol[i], 0);
    endtask

    task automatic run_line(input int i, input logic [63:0] value, input bit hex, input string name);
        int xfer;
        bit ok;
        cap_n[i]    = 0;
        viol[i]     = 0;
        first_dv[i] = -1;
        start_xfer(i, value, hex, xfer, ok);
        check(ok, {name, " ready_before"}, ok, 1);
        if (!ok) return;
        check(busy[i] && !in_ready[i], {name, " busy"}, {busy[i], in_ready[i]}, 2'b10);
        wait_ready(i, ok);
        check(ok, {name, " line_done"}, ok, 1);
        check(cyc == last_done[i] + 1, {name, " ready_latency"}, cyc - last_done[i], 1);
        check(first_dv[i] - xfer == exp_lat, {name, " first_dv_latency"}, first_dv[i] - xfer, exp_lat);
        check_capture(i, name);
    endtask

    typedef struct packed {
        logic [2:0]   inst;
        logic [63:0]  value;
        logic         hex;
        logic [127:0] txt;
        logic [7:0]   len;
        logic [7:0]   lat;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int          xfer, ri;
        bit          ok, rh;
        logic [63:0] rv;

        tbl[0] = '{3'd0, 64'hA5,  1'b0, 128'({"10100101", 8'h0A}),          8'd9,  8'd1};
        tbl[1] = '{3'd0, 64'hA5,  1'b1, 128'({"A5", 8'h0A}),                8'd3,  8'd1};
        tbl[2] = '{3'd1, 64'h3FF, 1'b1, 128'({"3FF", 8'h0A}),               8'd4,  8'd1};
        tbl[3] = '{3'd2, 64'h05,  1'b0, 128'({"101", 8'h0A}),               8'd4,  8'd6};
        tbl[4] = '{3'd2, 64'h00,  1'b0, 128'({"0", 8'h0A}),                 8'd2,  8'd8};
        tbl[5] = '{3'd3, 64'h0F,  1'b1, 128'({"0F", 8'h0D, 8'h0A}),         8'd4,  8'd1};
        tbl[6] = '{3'd2, 64'h00,  1'b1, 128'({"0", 8'h0A}),                 8'd2,  8'd2};
        tbl[7] = '{3'd2, 64'hFF,  1'b0, 128'({"11111111", 8'h0A}),          8'd9,  8'd1};
        tbl[8] = '{3'd1, 64'h005, 1'b1, 128'({"005", 8'h0A}),               8'd4,  8'd1};
        tbl[9] = '{3'd3, 64'h80,  1'b0, 128'({"10000000", 8'h0D, 8'h0A}),   8'd10, 8'd1};

        for (int i = 0; i < NI; i++) begin
            rst[i]      = 1'b1;
            in_valid[i] = 1'b0;
            in_data[i]  = '0;
            in_hex[i]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check(in_ready[i] === 1'b1, $sformatf("reset_ready%0d", i), in_ready[i], 1);
            check(busy[i] === 1'b0, $sformatf("reset_busy%0d", i), busy[i], 0);
            check(tx_dv[i] === 1'b0, $sformatf("reset_dv%0d", i), tx_dv[i], 0);
            check(tx_byte[i] === 8'h00, $sformatf("reset_byte%0d", i), tx_byte[i], 0);
        end

        for (int v = 0; v < 10; v++) begin
            exp_n = int'(tbl[v].len);
            for (int j = 0; j < exp_n; j++) exp_b[j] = tbl[v].txt[8*(exp_n-1-j) +: 8];
            exp_lat = int'(tbl[v].lat);
            run_line(int'(tbl[v].inst), tbl[v].value, tbl[v].hex, $sformatf("vec%0d", v));
        end

        // Back-to-back: IN_VALID held, data changed while the first line prints.
        cap_n[0] = 0;
        viol[0]  = 0;
        @(negedge clk);
        wait_ready(0, ok);
        in_valid[0] = 1'b1;
        in_data[0]  = 64'd1;
        in_hex[0]   = 1'b0;
        @(negedge clk);
        in_data[0] = 64'd2;
        wait_ready(0, ok);
        check(ok, "b2b line1_done", ok, 1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_ready(0, ok);
        check(ok, "b2b line2_done", ok, 1);
        model_line(0, 64'd1, 1'b0);
        begin
            int n1;
            logic [7:0] tmp [64];
            n1 = exp_n;
            for (int j = 0; j < n1; j++) tmp[j] = exp_b[j];
            model_line(0, 64'd2, 1'b0);
            for (int j = exp_n - 1; j >= 0; j--) exp_b[j + n1] = exp_b[j];
            for (int j = 0; j < n1; j++) exp_b[j] = tmp[j];
            exp_n = exp_n + n1;
        end
        check_capture(0, "b2b");

        // Reset while the third byte is in flight, then a stray DONE, then a clean line.
        cap_n[0] = 0;
        viol[0]  = 0;
        start_xfer(0, 64'hA5, 1'b0, xfer, ok);
        begin
            int t;
            t = 0;
            while (cap_n[0] < 3 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            check(cap_n[0] >= 3, "rst_mid third_byte", cap_n[0], 3);
        end
        repeat (10) @(negedge clk);
        stray[0] = 1'b1;
        rst[0]   = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check(in_ready[0] === 1'b1, "rst_mid ready", in_ready[0], 1);
        check(tx_dv[0] === 1'b0, "rst_mid dv", tx_dv[0], 0);
        check(tx_byte[0] === 8'h00, "rst_mid byte", tx_byte[0], 0);
        begin
            int t;
            t = 0;
            while (cnt[0] != 0 && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        repeat (3) @(negedge clk);
        check(in_ready[0] === 1'b1, "rst_mid stray_done_ready", in_ready[0], 1);
        check(cap_n[0] == 3, "rst_mid no_new_bytes", cap_n[0], 3);
        model_line(0, 64'h3C, 1'b0);
        run_line(0, 64'h3C, 1'b0, "after_rst");

        for (int r = 0; r < 20; r++) begin
            ri = int'($urandom_range(0, NI - 1));
            rv = {$urandom, $urandom};
            rh = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) rv = rv & 64'h1F;
            model_line(ri, rv, rh);
            run_line(ri, rv, rh, $sformatf("rand%0d_inst%0d", r, ri));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
